// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with a bounded hold time per owner
module rr_arbiter_16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_vld
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, nxt;
  logic [7:0] hold_cnt, hold_n;
  logic [15:0] gnt_n;
  logic [3:0] gnt_idx_n;
  logic gnt_vld_n, found, others, sat, keep;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 4'd15;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      gnt_idx  <= gnt_idx_n;
      gnt_vld  <= gnt_vld_n;
    end
  end
  // ptr is the owner while BUSY, so one circular search from ptr+1 serves grant, hand-off and preemption alike
  always_comb begin
    nxt    = ptr;
    found  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (!found && req[ptr + 4'(i)]) begin
        found = 1'b1;
        nxt   = ptr + 4'(i);
      end
    end
    others  = |(req & ~(16'd1 << ptr));
    sat     = hold_cnt >= 8'(MAX_HOLD - 1);
    keep    = (state == BUSY) && req[ptr] && (!sat || !others);
    state_n = found ? BUSY : IDLE;
    ptr_n   = (keep || !found) ? ptr : nxt;
    hold_n  = keep ? (sat ? hold_cnt : hold_cnt + 8'd1) : 8'd0;
  end
  always_comb begin
    gnt_vld_n = state_n == BUSY;
    gnt_idx_n = gnt_vld_n ? ptr_n : 4'd0;
    gnt_n     = gnt_vld_n ? 16'd1 << ptr_n : 16'd0;
  end
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: random and directed checks of two arbiter instances against a round-robin model
module tb_rr_arbiter_16;
  logic clk, rst;
  logic [15:0] req, g8, g1;
  logic [3:0] i8, i1;
  logic v8, v1;
  int tests, fails;
  int own[2], last[2], held[2], maxw[2];
  int mh[2] = '{8, 1};
  int wt[2][16];
  logic [15:0] r, nr;

  rr_arbiter_16 u8 (.clk(clk), .rst(rst), .req(req), .gnt(g8), .gnt_idx(i8), .gnt_vld(v8));
  rr_arbiter_16 #(.MAX_HOLD(1)) u1 (.clk(clk), .rst(rst), .req(req), .gnt(g1), .gnt_idx(i1), .gnt_vld(v1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] eg(input int d);
    return own[d] < 0 ? 16'd0 : 16'd1 << own[d];
  endfunction

  // owner keeps the grant until it drops, or until it has held mh cycles and someone else waits
  task automatic mstep(input int d, input logic [15:0] rq, input logic rs);
    logic [15:0] oth;
    if (rs) begin
      own[d] = -1; last[d] = 15; held[d] = 0;
    end else begin
      oth = own[d] >= 0 ? rq & ~(16'd1 << own[d]) : rq;
      if (own[d] >= 0 && rq[own[d]] && (held[d] < mh[d] || oth == 0)) begin
        if (held[d] < mh[d]) held[d]++;
      end else if (rq != 0) begin
        for (int k = 1; k <= 16; k++) begin
          if (rq[(last[d] + k) % 16]) begin
            own[d] = (last[d] + k) % 16; last[d] = own[d]; held[d] = 1;
            break;
          end
        end
      end else own[d] = -1;
    end
  endtask

  task automatic cyc(input logic [15:0] rq, input logic rs);
    logic [15:0] gd;
    req = rq; rst = rs;
    @(posedge clk);
    mstep(0, rq, rs);
    mstep(1, rq, rs);
    #1;
    chk("gnt8", g8, eg(0));
    chk("idx8", i8, own[0] < 0 ? 0 : own[0]);
    chk("vld8", v8, own[0] >= 0);
    chk("gnt1", g1, eg(1));
    chk("idx1", i1, own[1] < 0 ? 0 : own[1]);
    chk("vld1", v1, own[1] >= 0);
    for (int d = 0; d < 2; d++) begin
      gd = d == 0 ? g8 : g1;
      for (int n = 0; n < 16; n++) begin
        if (!rs && rq[n] && !gd[n]) begin
          wt[d][n]++;
          if (wt[d][n] > maxw[d]) maxw[d] = wt[d][n];
        end else wt[d][n] = 0;
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; maxw = '{0, 0};
    own = '{-1, -1}; last = '{15, 15}; held = '{0, 0};
    for (int d = 0; d < 2; d++) for (int n = 0; n < 16; n++) wt[d][n] = 0;
    req = '0; rst = 1'b1;
    cyc(16'h0000, 1'b1);
    cyc(16'h0000, 1'b1);
    chk("rst_gnt", g8, 16'h0000);
    chk("rst_vld", v8, 0);
    for (int c = 0; c < 5; c++) begin
      cyc(16'h0000, 1'b0);
      chk("idle_gnt", g8, 16'h0000);
      chk("idle_idx", i8, 0);
    end
    cyc(16'h8001, 1'b0);
    chk("hold_first", g8, 16'h0001);
    for (int c = 0; c < 7; c++) cyc(16'h8001, 1'b0);
    chk("hold_last", g8, 16'h0001);
    cyc(16'h8001, 1'b0);
    chk("preempt", g8, 16'h8000);
    chk("preempt_idx", i8, 15);
    for (int c = 0; c < 7; c++) cyc(16'h8001, 1'b0);
    cyc(16'h8001, 1'b0);
    chk("wrap", g8, 16'h0001);
    cyc(16'h0000, 1'b1);
    cyc(16'h0008, 1'b0);
    chk("own3", g8, 16'h0008);
    cyc(16'h0028, 1'b0);
    cyc(16'h0020, 1'b0);
    chk("handoff", g8, 16'h0020);
    chk("handoff_vld", v8, 1);
    cyc(16'h0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cyc(16'h0400, 1'b0);
      chk("single", g8, 16'h0400);
    end
    cyc(16'h0401, 1'b0);
    chk("sat_preempt", g8, 16'h0001);
    cyc(16'h0000, 1'b1);
    cyc(16'h0020, 1'b0);
    chk("own5", g8, 16'h0020);
    cyc(16'hFFFF, 1'b1);
    chk("rst_mid", g8, 16'h0000);
    cyc(16'hFFFF, 1'b0);
    chk("rst_after", g8, 16'h0001);
    cyc(16'h0000, 1'b1);
    for (int c = 0; c < 6; c++) begin
      cyc(16'h0007, 1'b0);
      chk("rot1", g1, 16'd1 << (c % 3));
    end
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      nr = r & ~(($urandom_range(0, 3) == 0) ? eg(0) : 16'h0000);
      nr = nr | (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 63) == 0) nr = '0;
      r = nr;
      cyc(r, $urandom_range(0, 499) == 0);
    end
    chk("starve8", int'(maxw[0] <= 15 * 8 + 1), 1);
    chk("starve1", int'(maxw[1] <= 15 * 1 + 1), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
